// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared PPU types, screen constants and DMG shade table
package ppu_pkg;

  typedef logic [14:0] rgb555_t;

  localparam int LCD_W = 160;
  localparam int LCD_H = 144;

  localparam rgb555_t COLOR_WHITE = 15'h7FFF;

  // Index is the 2-bit DMG shade; 0 is lightest.
  localparam rgb555_t DMG_SHADE [4] = '{15'h7FFF, 15'h5AD6, 15'h294A, 15'h0000};

  typedef enum logic [1:0] {
    FW_IDLE,
    FW_ACTIVE,
    FW_BLANK
  } fw_state_t;

  function automatic rgb555_t dmg_to_rgb(input logic [1:0] shade);
    return DMG_SHADE[shade];
  endfunction

endpackage

// File: rtl/lcd_frame_writer_if.sv
// rtl/lcd_frame_writer_if.sv - framebuffer write port
//   fb_addr  : write address (y*W + x)
//   fb_wdata : RGB555 pixel
//   fb_write : request; a transfer happens when fb_write && fb_ready
//   fb_ready : framebuffer accepts this cycle
interface lcd_frame_writer_if #(
  parameter int ADDR_W = 15
) ();
  import ppu_pkg::*;

  logic [ADDR_W-1:0] fb_addr;
  rgb555_t           fb_wdata;
  logic              fb_write;
  logic              fb_ready;

  modport master (output fb_addr, output fb_wdata, output fb_write, input fb_ready);
  modport slave  (input fb_addr, input fb_wdata, input fb_write, output fb_ready);

endinterface

// File: rtl/lcd_frame_writer_fifo.sv
// rtl/lcd_frame_writer_fifo.sv - small synchronous FIFO for framebuffer writes
//   push/push_data : enqueue (ignored when full)
//   pop            : dequeue head (ignored when empty)
//   head           : oldest entry, forced to zero while empty
//   full/empty     : occupancy flags
module fb_write_fifo #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/lcd_frame_writer.sv
// rtl/lcd_frame_writer.sv - final PPU stage: colour expand, position tracking, framebuffer writes
//   clk, reset    : clock, synchronous active-low reset
//   ppu_enable    : LCD enable; falling edge starts a white fill
//   cgb           : 1 = pixel_color is RGB555, 0 = pixel_color[1:0] is a DMG shade
//   pixel_color   : colour from the colouring stage
//   pixel_valid   : pixel strobe
//   frame_start   : strobe at start of line 0
//   fb            : framebuffer write port (master)
//   frame_done    : pulse after the last pixel of a frame is queued
//   overflow      : sticky, a pixel was dropped on a full queue
module lcd_frame_writer
  import ppu_pkg::*;
#(
  parameter int H_PIXELS   = LCD_W,
  parameter int V_PIXELS   = LCD_H,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ppu_enable,
  input  logic                cgb,
  input  rgb555_t             pixel_color,
  input  logic                pixel_valid,
  input  logic                frame_start,
  lcd_frame_writer_if.master  fb,
  output logic                frame_done,
  output logic                overflow
);

  localparam int XW = $clog2(H_PIXELS);
  localparam int YW = $clog2(V_PIXELS);
  localparam logic [XW-1:0]     X_LAST    = XW'(H_PIXELS - 1);
  localparam logic [YW-1:0]     Y_LAST    = YW'(V_PIXELS - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_PIXELS * V_PIXELS - 1);

  fw_state_t         state, state_nxt;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [ADDR_W-1:0] addr_q;
  logic              en_q;
  logic              en_fall;

  logic [XW-1:0]     x_base, x_adv;
  logic [YW-1:0]     y_base, y_adv;
  logic [ADDR_W-1:0] addr_base, addr_adv;
  logic              line_end, frame_end;

  logic              push;
  logic [ADDR_W-1:0] push_addr;
  rgb555_t           push_color;
  rgb555_t           color_exp;
  logic              full, empty;
  logic [ADDR_W+14:0] head;

  assign en_fall   = en_q && !ppu_enable;
  assign color_exp = cgb ? pixel_color : dmg_to_rgb(pixel_color[1:0]);

  // A frame_start arriving with a pixel places that pixel at the origin.
  assign x_base    = frame_start ? '0 : x_q;
  assign y_base    = frame_start ? '0 : y_q;
  assign addr_base = frame_start ? '0 : addr_q;
  assign line_end  = (x_base == X_LAST);
  assign frame_end = line_end && (y_base == Y_LAST);
  assign x_adv     = line_end ? '0 : x_base + XW'(1);
  assign y_adv     = line_end ? ((y_base == Y_LAST) ? '0 : y_base + YW'(1)) : y_base;
  assign addr_adv  = frame_end ? '0 : addr_base + ADDR_W'(1);

  always_comb begin
    state_nxt  = state;
    push       = 1'b0;
    push_addr  = addr_q;
    push_color = color_exp;
    case (state)
      FW_IDLE: begin
        if (frame_start && ppu_enable) state_nxt = FW_ACTIVE;
      end
      FW_ACTIVE: begin
        if (en_fall) begin
          state_nxt = FW_BLANK;
        end else if (pixel_valid) begin
          push      = !full;
          push_addr = addr_base;
        end
      end
      FW_BLANK: begin
        push       = !full;
        push_color = COLOR_WHITE;
        if (!full && addr_q == ADDR_LAST) state_nxt = FW_IDLE;
      end
      default: state_nxt = FW_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= FW_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      addr_q     <= '0;
      en_q       <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      en_q       <= ppu_enable;
      frame_done <= 1'b0;
      case (state)
        FW_IDLE: begin
          if (frame_start) overflow <= 1'b0;
        end
        FW_ACTIVE: begin
          if (en_fall) begin
            // Fill starts at the origin; position restarts there afterwards too.
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
          end else if (pixel_valid) begin
            // Dropped pixels still advance so the screen position stays aligned.
            x_q        <= x_adv;
            y_q        <= y_adv;
            addr_q     <= addr_adv;
            frame_done <= !full && frame_end;
            if (full)             overflow <= 1'b1;
            else if (frame_start) overflow <= 1'b0;
          end else if (frame_start) begin
            x_q      <= '0;
            y_q      <= '0;
            addr_q   <= '0;
            overflow <= 1'b0;
          end
        end
        FW_BLANK: begin
          if (!full) addr_q <= (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  fb_write_fifo #(
    .WIDTH (ADDR_W + 15),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({push_addr, push_color}),
    .pop       (fb.fb_ready),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign fb.fb_addr  = head[ADDR_W+14:15];
  assign fb.fb_wdata = head[14:0];
  assign fb.fb_write = !empty;

endmodule

// File: tb/tb_lcd_frame_writer.sv
// tb/tb_lcd_frame_writer.sv - directed-vector bench for lcd_frame_writer
module tb_lcd_frame_writer;

  localparam int NPIX = 160 * 144;

  logic        clk = 1'b0;
  logic        reset;
  logic        ppu_enable;
  logic        cgb;
  logic [14:0] pixel_color;
  logic        pixel_valid;
  logic        frame_start;
  logic        frame_done;
  logic        overflow;

  lcd_frame_writer_if #(.ADDR_W(15)) fbif ();

  lcd_frame_writer dut (
    .clk         (clk),
    .reset       (reset),
    .ppu_enable  (ppu_enable),
    .cgb         (cgb),
    .pixel_color (pixel_color),
    .pixel_valid (pixel_valid),
    .frame_start (frame_start),
    .fb          (fbif),
    .frame_done  (frame_done),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int fd_cnt = 0;
  logic [31:0] wa_q [$];
  logic [31:0] wd_q [$];

  always @(negedge clk) begin
    if (reset) begin
      if (fbif.fb_write && fbif.fb_ready) begin
        wa_q.push_back(32'(fbif.fb_addr));
        wd_q.push_back(32'(fbif.fb_wdata));
      end
      if (frame_done) fd_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pixel(input logic [14:0] color, input logic fs);
    pixel_color = color;
    pixel_valid = 1'b1;
    frame_start = fs;
    tick();
    pixel_valid = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic drain(input string tag);
    int cyc = 0;
    while (fbif.fb_write && cyc < 64) begin
      tick();
      cyc++;
    end
    tick();
    check(tag, 32'(fbif.fb_write), 32'd0);
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
  endtask

  initial begin
    int errs;
    int cyc;
    reset         = 1'b0;
    ppu_enable    = 1'b0;
    cgb           = 1'b0;
    pixel_color   = '0;
    pixel_valid   = 1'b0;
    frame_start   = 1'b0;
    fbif.fb_ready = 1'b1;
    repeat (3) tick();

    check("rst_write", 32'(fbif.fb_write), 32'd0);
    check("rst_addr",  32'(fbif.fb_addr),  32'd0);
    check("rst_wdata", 32'(fbif.fb_wdata), 32'd0);
    check("rst_done",  32'(frame_done),    32'd0);
    check("rst_ovf",   32'(overflow),      32'd0);

    // DMG shades
    reset = 1'b1;
    ppu_enable = 1'b1;
    tick();
    pulse_frame_start();
    clear_log();
    send_pixel(15'h7FFC, 1'b0);
    check("dmg_lat_write", 32'(fbif.fb_write), 32'd1);
    check("dmg_lat_addr",  32'(fbif.fb_addr),  32'd0);
    check("dmg_lat_data",  32'(fbif.fb_wdata), 32'h7FFF);
    send_pixel(15'h0001, 1'b0);
    send_pixel(15'h2AAB, 1'b0);
    drain("dmg_drain");
    check("dmg_count", 32'(wa_q.size()), 32'd3);
    if (wa_q.size() == 3) begin
      check("dmg_a0", wa_q[0], 32'd0); check("dmg_d0", wd_q[0], 32'h7FFF);
      check("dmg_a1", wa_q[1], 32'd1); check("dmg_d1", wd_q[1], 32'h5AD6);
      check("dmg_a2", wa_q[2], 32'd2); check("dmg_d2", wd_q[2], 32'h0000);
    end

    // Full CGB frame
    cgb = 1'b1;
    pulse_frame_start();
    clear_log();
    fd_cnt = 0;
    for (int i = 0; i < NPIX; i++) begin
      send_pixel(15'(i), 1'b0);
      if (i == NPIX - 2) check("frm_done_early", 32'(frame_done), 32'd0);
      if (i == NPIX - 1) check("frm_done_pulse", 32'(frame_done), 32'd1);
    end
    tick();
    check("frm_done_clear", 32'(frame_done), 32'd0);
    drain("frm_drain");
    check("frm_done_cnt", 32'(fd_cnt), 32'd1);
    check("frm_count", 32'(wa_q.size()), 32'(NPIX));
    errs = 0;
    for (int k = 0; k < wa_q.size(); k++)
      if (wa_q[k] != 32'(k) || wd_q[k] != 32'(k)) errs++;
    check("frm_seq_errs", 32'(errs), 32'd0);
    if (wa_q.size() > 160) check("frm_px160", wa_q[160], 32'd160);

    // Backpressure
    pulse_frame_start();
    clear_log();
    fbif.fb_ready = 1'b0;
    for (int i = 0; i < 6; i++) send_pixel(15'h100 + 15'(i), 1'b0);
    tick();
    check("bp_ovf",   32'(overflow),      32'd1);
    check("bp_write", 32'(fbif.fb_write), 32'd1);
    check("bp_addr",  32'(fbif.fb_addr),  32'd0);
    check("bp_data",  32'(fbif.fb_wdata), 32'h100);
    fbif.fb_ready = 1'b1;
    drain("bp_drain");
    check("bp_count", 32'(wa_q.size()), 32'd4);
    if (wa_q.size() == 4)
      for (int k = 0; k < 4; k++) begin
        check("bp_addr_k", wa_q[k], 32'(k));
        check("bp_data_k", wd_q[k], 32'h100 + 32'(k));
      end
    clear_log();
    send_pixel(15'h200, 1'b0);
    drain("bp_next_drain");
    check("bp_next_cnt", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() == 1) check("bp_next_addr", wa_q[0], 32'd6);
    check("bp_ovf_sticky", 32'(overflow), 32'd1);
    pulse_frame_start();
    check("bp_ovf_clear", 32'(overflow), 32'd0);

    // Resync at (10,20)
    clear_log();
    for (int i = 0; i < 20 * 160 + 10; i++) send_pixel(15'(i), 1'b0);
    drain("rs_drain");
    if (wa_q.size() > 0) check("rs_last_addr", wa_q[wa_q.size()-1], 32'd3209);
    clear_log();
    pulse_frame_start();
    send_pixel(15'h55, 1'b0);
    send_pixel(15'h66, 1'b1);
    send_pixel(15'h77, 1'b0);
    drain("rs_drain2");
    check("rs_count", 32'(wa_q.size()), 32'd3);
    if (wa_q.size() == 3) begin
      check("rs_a0", wa_q[0], 32'd0);
      check("rs_a1", wa_q[1], 32'd0); check("rs_d1", wd_q[1], 32'h66);
      check("rs_a2", wa_q[2], 32'd1); check("rs_d2", wd_q[2], 32'h77);
    end

    // Disable mid-line -> white fill
    pulse_frame_start();
    for (int i = 0; i < 50; i++) send_pixel(15'h1000, 1'b0);
    drain("bl_pre_drain");
    clear_log();
    ppu_enable  = 1'b0;
    pixel_valid = 1'b1;
    pixel_color = 15'h1234;
    cyc = 0;
    while (wa_q.size() < NPIX && cyc < 24000) begin
      tick();
      cyc++;
      if (cyc == 100) ppu_enable = 1'b1;
      frame_start = (cyc == 200);
    end
    frame_start = 1'b0;
    check("bl_timeout", 32'(cyc < 24000), 32'd1);
    repeat (5) tick();
    check("bl_count", 32'(wa_q.size()), 32'(NPIX));
    errs = 0;
    for (int k = 0; k < wa_q.size(); k++)
      if (wa_q[k] != 32'(k) || wd_q[k] != 32'h7FFF) errs++;
    check("bl_seq_errs", 32'(errs), 32'd0);
    clear_log();
    repeat (20) tick();
    pixel_valid = 1'b0;
    check("idle_no_write", 32'(wa_q.size()), 32'd0);

    // Reset during fill with a full queue
    pulse_frame_start();
    fbif.fb_ready = 1'b0;
    for (int i = 0; i < 6; i++) send_pixel(15'h300, 1'b0);
    check("r6_ovf", 32'(overflow), 32'd1);
    ppu_enable = 1'b0;
    repeat (3) tick();
    check("r6_pre_write", 32'(fbif.fb_write), 32'd1);
    reset = 1'b0;
    tick();
    check("r6_write", 32'(fbif.fb_write), 32'd0);
    check("r6_addr",  32'(fbif.fb_addr),  32'd0);
    check("r6_wdata", 32'(fbif.fb_wdata), 32'd0);
    check("r6_ovf_clr", 32'(overflow),    32'd0);
    check("r6_done",  32'(frame_done),    32'd0);
    reset = 1'b1;
    fbif.fb_ready = 1'b1;
    repeat (5) tick();
    check("r6_idle_write", 32'(fbif.fb_write), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
